// File: rtl/tt_project_sequencer.sv
// tt_project_sequencer
//
// Shares one set of Tiny Tapeout pins between N_PROJ user projects. A select
// request powers down the current project for one cycle (DRAIN), enables
// the new project while holding the shared reset low for RST_HOLD cycles
// (HOLD), then releases reset and routes the pins to it (RUN).
//
// Parameters:
//   N_PROJ    number of attached projects, 1..15
//   RST_HOLD  cycles proj_rst_n is held low with ena high, 1..255
//
// Ports:
//   clk, rst           clock and synchronous active-high reset
//   sel_req/sel_addr   one-cycle select strobe and project index (4'hF = none)
//   sel_busy           selection sequence in progress (DRAIN or HOLD)
//   sel_err            one-cycle pulse after a rejected request
//   cur_valid/cur_addr running project flag and index (index 0 when idle)
//   ena                one-hot-or-zero project enables
//   proj_rst_n         shared active-low project reset
//   ui_in/proj_ui      pad inputs and gated copy fed to the projects
//   proj_uo/uo_out     concatenated project outputs and selected pad outputs
//
// Build option:
//   TT_SEQ_UO_REG_EN   when defined, uo_out is registered (one cycle behind
//                      the output mux, cleared by reset)

module tt_project_sequencer #(
  parameter int N_PROJ   = 4,
  parameter int RST_HOLD = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sel_req,
  input  logic [3:0]          sel_addr,
  output logic                sel_busy,
  output logic                sel_err,
  output logic                cur_valid,
  output logic [3:0]          cur_addr,
  output logic [N_PROJ-1:0]   ena,
  output logic                proj_rst_n,
  input  logic [7:0]          ui_in,
  output logic [7:0]          proj_ui,
  input  logic [8*N_PROJ-1:0] proj_uo,
  output logic [7:0]          uo_out
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2,
    ST_RUN   = 2'd3
  } state_t;

  localparam logic [7:0] HOLD_LAST = 8'(RST_HOLD - 1);
  localparam logic [4:0] N_PROJ_W  = 5'(N_PROJ);

  state_t              state_q, state_d;
  logic [3:0]          addr_q, addr_d;
  logic [7:0]          cnt_q, cnt_d;
  logic                sel_err_q, sel_err_d;
  logic                sel_busy_q, sel_busy_d;
  logic                cur_valid_q, cur_valid_d;
  logic [3:0]          cur_addr_q, cur_addr_d;
  logic [N_PROJ-1:0]   ena_q, ena_d;
  logic                proj_rst_n_q, proj_rst_n_d;

  logic                req_valid;
  logic                req_desel;
  logic [7:0]          uo_mux;

  // Request classification: a legal project index, or the deselect code.
  // 4'hF can never be a legal index because N_PROJ is at most 15.
  always_comb begin
    req_valid = ({1'b0, sel_addr} < N_PROJ_W);
    req_desel = (sel_addr == 4'hF);
  end

  // Sequencer next state. Requests are only honoured in IDLE and RUN;
  // during DRAIN and HOLD they are dropped without an error.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    sel_err_d = 1'b0;
    case (state_q)
      ST_IDLE, ST_RUN: begin
        if (sel_req) begin
          if (req_valid) begin
            // Same index as the running project restarts it.
            addr_d  = sel_addr;
            state_d = ST_DRAIN;
          end else begin
            addr_d    = '0;
            state_d   = ST_IDLE;
            sel_err_d = !req_desel;
          end
        end
      end
      ST_DRAIN: begin
        state_d = ST_HOLD;
        cnt_d   = '0;
      end
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = ST_RUN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        addr_d  = '0;
      end
    endcase
  end

  // Registered outputs are decoded from the next state so they change on
  // the same edge as the state itself, with no decode glitches on the pins.
  always_comb begin
    sel_busy_d   = (state_d == ST_DRAIN) || (state_d == ST_HOLD);
    cur_valid_d  = (state_d == ST_RUN);
    cur_addr_d   = (state_d == ST_RUN) ? addr_d : 4'd0;
    proj_rst_n_d = (state_d == ST_RUN);
    ena_d        = '0;
    for (int unsigned k = 0; k < N_PROJ; k++) begin
      if ((addr_d == 4'(k)) &&
          ((state_d == ST_HOLD) || (state_d == ST_RUN))) begin
        ena_d[k] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      cnt_q        <= '0;
      sel_err_q    <= 1'b0;
      sel_busy_q   <= 1'b0;
      cur_valid_q  <= 1'b0;
      cur_addr_q   <= '0;
      ena_q        <= '0;
      proj_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      sel_err_q    <= sel_err_d;
      sel_busy_q   <= sel_busy_d;
      cur_valid_q  <= cur_valid_d;
      cur_addr_q   <= cur_addr_d;
      ena_q        <= ena_d;
      proj_rst_n_q <= proj_rst_n_d;
    end
  end

  assign sel_err    = sel_err_q;
  assign sel_busy   = sel_busy_q;
  assign cur_valid  = cur_valid_q;
  assign cur_addr   = cur_addr_q;
  assign ena        = ena_q;
  assign proj_rst_n = proj_rst_n_q;

  // Projects see the pad inputs only once they are enabled, so inputs are
  // already stable while their reset is asserted.
  always_comb begin
    proj_ui = '0;
    if ((state_q == ST_HOLD) || (state_q == ST_RUN)) begin
      proj_ui = ui_in;
    end
  end

  // Output mux: only the running project drives the pads.
  always_comb begin
    uo_mux = '0;
    for (int unsigned k = 0; k < N_PROJ; k++) begin
      if ((state_q == ST_RUN) && (addr_q == 4'(k))) begin
        uo_mux = proj_uo[8*k +: 8];
      end
    end
  end

`ifdef TT_SEQ_UO_REG_EN
  logic [7:0] uo_q, uo_d;

  always_comb begin
    uo_d = uo_mux;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_q <= '0;
    end else begin
      uo_q <= uo_d;
    end
  end

  assign uo_out = uo_q;
`else
  assign uo_out = uo_mux;
`endif

endmodule

// File: tb/tb_tt_project_sequencer.sv
// Self-checking bench for tt_project_sequencer (N_PROJ = 4, RST_HOLD = 8).
// A cycle-age model predicts every output each cycle; directed literal
// checks pin the model at the key points of each scenario.

module tb_tt_project_sequencer;

  localparam int N  = 4;
  localparam int RH = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           sel_req;
  logic [3:0]     sel_addr;
  logic           sel_busy;
  logic           sel_err;
  logic           cur_valid;
  logic [3:0]     cur_addr;
  logic [N-1:0]   ena;
  logic           proj_rst_n;
  logic [7:0]     ui_in;
  logic [7:0]     proj_ui;
  logic [8*N-1:0] proj_uo;
  logic [7:0]     uo_out;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  tt_project_sequencer #(
    .N_PROJ   (N),
    .RST_HOLD (RH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sel_req    (sel_req),
    .sel_addr   (sel_addr),
    .sel_busy   (sel_busy),
    .sel_err    (sel_err),
    .cur_valid  (cur_valid),
    .cur_addr   (cur_addr),
    .ena        (ena),
    .proj_rst_n (proj_rst_n),
    .ui_in      (ui_in),
    .proj_ui    (proj_ui),
    .proj_uo    (proj_uo),
    .uo_out     (uo_out)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: m_age counts cycles since the accepted request edge.
  // age 1 = drain, 2..RH+1 = hold, RH+2 (saturating) = run.
  bit         m_on  = 1'b0;
  bit         m_seq = 1'b0;
  int         m_age = 0;
  int         m_addr = 0;
  bit         m_err = 1'b0;
  logic [7:0] m_uo_reg = 8'h00;

  always @(posedge clk) begin : model
    bit busy;
    bit run_now;
    run_now  = m_seq && (m_age >= RH + 2);
    m_uo_reg = run_now ? proj_uo[m_addr*8 +: 8] : 8'h00;
    if (rst) begin
      m_on     = 1'b1;
      m_seq    = 1'b0;
      m_age    = 0;
      m_addr   = 0;
      m_err    = 1'b0;
      m_uo_reg = 8'h00;
    end else begin
      busy  = m_seq && (m_age <= RH + 1);
      m_err = 1'b0;
      if (sel_req && !busy) begin
        if (sel_addr < N) begin
          m_seq  = 1'b1;
          m_addr = sel_addr;
          m_age  = 1;
        end else begin
          m_seq  = 1'b0;
          m_addr = 0;
          m_age  = 0;
          m_err  = (sel_addr != 4'hF);
        end
      end else if (m_seq && (m_age < RH + 2)) begin
        m_age++;
      end
    end
  end

  initial begin : compare
    bit         e_run, e_hold, e_drain;
    logic [N-1:0] e_ena;
    logic [7:0] e_uo, e_ui;
    forever begin
      @(posedge clk);
      #2;
      if (m_on) begin
        e_run   = m_seq && (m_age >= RH + 2);
        e_hold  = m_seq && (m_age >= 2) && (m_age <= RH + 1);
        e_drain = m_seq && (m_age == 1);
        e_ena   = '0;
        if (e_run || e_hold) e_ena[m_addr] = 1'b1;
        e_ui = (e_run || e_hold) ? ui_in : 8'h00;
`ifdef TT_SEQ_UO_REG_EN
        e_uo = m_uo_reg;
`else
        e_uo = e_run ? proj_uo[m_addr*8 +: 8] : 8'h00;
`endif
        chk("m_sel_busy",   sel_busy,   e_drain || e_hold);
        chk("m_sel_err",    sel_err,    m_err);
        chk("m_cur_valid",  cur_valid,  e_run);
        chk("m_cur_addr",   cur_addr,   e_run ? m_addr : 0);
        chk("m_ena",        ena,        e_ena);
        chk("m_proj_rst_n", proj_rst_n, e_run);
        chk("m_proj_ui",    proj_ui,    e_ui);
        chk("m_uo_out",     uo_out,     e_uo);
        chk("m_ena_onehot", 32'($countones(ena) <= 1), 1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #3;
    ui_in = 8'($urandom);
  endtask

  // Returns in cycle T0+1, where T0 is the edge that sampled the request.
  task automatic request(input logic [3:0] a);
    sel_req  = 1'b1;
    sel_addr = a;
    tick();
    sel_req  = 1'b0;
    sel_addr = 4'($urandom);
  endtask

  task automatic wait_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin : stim
    int zeros;
    rst      = 1'b1;
    sel_req  = 1'b0;
    sel_addr = 4'h0;
    ui_in    = 8'h00;
    proj_uo  = 32'hD3C2B1A0;
    wait_n(2);
    chk("rst_ena",     ena,        0);
    chk("rst_rstn",    proj_rst_n, 0);
    chk("rst_busy",    sel_busy,   0);
    chk("rst_valid",   cur_valid,  0);
    chk("rst_err",     sel_err,    0);
    chk("rst_uo",      uo_out,     0);
    chk("rst_ui",      proj_ui,    0);
    rst = 1'b0;
    tick();

    // Select project 2
    request(4'd2);
    chk("sel_drain_ena",  ena,      0);
    chk("sel_drain_busy", sel_busy, 1);
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("sel_hold_ena",  ena,        4'b0100);
      chk("sel_hold_rstn", proj_rst_n, 0);
    end
    tick();
    chk("sel_run_valid", cur_valid,  1);
    chk("sel_run_addr",  cur_addr,   2);
    chk("sel_run_rstn",  proj_rst_n, 1);
    chk("sel_run_busy",  sel_busy,   0);
`ifdef TT_SEQ_UO_REG_EN
    chk("sel_run_uo_first", uo_out, 8'h00);
`else
    chk("sel_run_uo_first", uo_out, 8'hC2);
`endif
    tick();
    chk("sel_run_uo", uo_out, 8'hC2);

    // Switch from project 1 to project 3
    request(4'd1);
    wait_n(10);
    chk("sw_run1_addr", cur_addr, 1);
    request(4'd3);
    zeros = (ena == '0) ? 1 : 0;
    chk("sw_uo_drain", uo_out, 0);
    for (int i = 2; i <= 11; i++) begin
      tick();
      if (ena == '0) zeros++;
      if (i <= 9) chk("sw_uo_hold", uo_out, 0);
      if (i == 11) chk("sw_uo_run", uo_out, 8'hD3);
    end
    chk("sw_zero_cycles", zeros, 1);

    // Invalid request, deselect, invalid from idle
    request(4'd5);
    chk("inv_err",   sel_err,   1);
    chk("inv_valid", cur_valid, 0);
    chk("inv_ena",   ena,       0);
    chk("inv_busy",  sel_busy,  0);
    tick();
    chk("inv_err_clear", sel_err, 0);
    request(4'hF);
    chk("desel_err",   sel_err,   0);
    chk("desel_valid", cur_valid, 0);
    chk("desel_busy",  sel_busy,  0);
    tick();
    request(4'hE);
    chk("inv_idle_err", sel_err, 1);
    tick();
    chk("inv_idle_err_clear", sel_err, 0);

    // Request during HOLD is ignored
    request(4'd1);
    wait_n(3);
    request(4'd0);
    chk("busy_no_err", sel_err, 0);
    wait_n(5);
    chk("busy_valid", cur_valid, 1);
    chk("busy_addr",  cur_addr,  1);
    chk("busy_ena",   ena,       4'b0010);

    // Reset during the 4th HOLD cycle
    request(4'd3);
    wait_n(4);
    rst = 1'b1;
    tick();
    chk("mrst_ena",   ena,        0);
    chk("mrst_rstn",  proj_rst_n, 0);
    chk("mrst_busy",  sel_busy,   0);
    chk("mrst_valid", cur_valid,  0);
    chk("mrst_addr",  cur_addr,   0);
    chk("mrst_uo",    uo_out,     0);
    chk("mrst_ui",    proj_ui,    0);
    rst = 1'b0;
    tick();
    request(4'd2);
    chk("mrst_sel_busy", sel_busy, 1);
    wait_n(8);
    chk("mrst_sel_rstn", proj_rst_n, 0);
    chk("mrst_sel_ena",  ena,        4'b0100);
    tick();
    chk("mrst_sel_valid", cur_valid, 1);

    // Same-address restart of project 0
    request(4'd0);
    wait_n(9);
    chk("rs_run0_valid", cur_valid, 1);
    chk("rs_run0_addr",  cur_addr,  0);
    request(4'd0);
    chk("rs_drain_ena",   ena,       0);
    chk("rs_drain_busy",  sel_busy,  1);
    chk("rs_drain_valid", cur_valid, 0);
    for (int i = 2; i <= 9; i++) begin
      tick();
      chk("rs_hold_rstn", proj_rst_n, 0);
      chk("rs_hold_ena",  ena,        4'b0001);
    end
    tick();
    chk("rs_run_valid", cur_valid,  1);
    chk("rs_run_rstn",  proj_rst_n, 1);

    // Changing project outputs exercise the output path latency
    for (int i = 0; i < 6; i++) begin
      proj_uo = (8*N)'($urandom);
      tick();
    end
    proj_uo = 32'h1111115A;
    tick();
    chk("lag_uo_settled", uo_out, 8'h5A);
    proj_uo = 32'h111111A5;
    #1;
`ifdef TT_SEQ_UO_REG_EN
    chk("lag_uo_step", uo_out, 8'h5A);
`else
    chk("lag_uo_step", uo_out, 8'hA5);
`endif
    tick();
    chk("lag_uo_after", uo_out, 8'hA5);
    wait_n(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_project_sequencer.md
# tt_project_sequencer

Controller that shares one set of Tiny Tapeout pins (`ui_in`/`uo_out`) between `N_PROJ` user projects (`tt_um_*` instances). It accepts a project-select request, powers down the old selection, and enables the new project with a timed reset pulse. It then routes inputs to the active project and its outputs back to the pins. It sits between the chip-level pad logic and the array of user projects, and it is the only driver of each project's `ena` and `rst_n`.

## Interface
Parameters:
- `N_PROJ`, default 4: number of attached projects, 1..15.
- `RST_HOLD`, default 8: cycles that `proj_rst_n` is held low with `ena` high, 1..255.

Ports:
- `clk`, input, 1: single clock. All logic is on the rising edge.
- `rst`, input, 1: reset. It is synchronous and active-high.
- `sel_req`, input, 1: one-cycle select request strobe.
- `sel_addr`, input, 4: project index sampled with `sel_req`.
  - `4'hF` means deselect all.
- `sel_busy`, output, 1: high while a selection sequence is in progress.
- `sel_err`, output, 1: one-cycle pulse when a request is rejected.
- `cur_valid`, output, 1: a project is selected and running.
- `cur_addr`, output, 4: index of the running project.
  - Value is 0 when `cur_valid` = 0.
- `ena`, output, N_PROJ: one-hot-or-zero enable, one bit per project.
- `proj_rst_n`, output, 1: shared active-low project reset.
- `ui_in`, input, 8: pad inputs.
- `proj_ui`, output, 8: inputs to the projects.
- `proj_uo`, input, 8*N_PROJ: project outputs, concatenated.
  - Project k drives bits [8k+7:8k].
- `uo_out`, output, 8: pad outputs.

## Operation
Reset (`rst` = 1 at an edge) sets all of the following at that edge:
- `state` = IDLE.
- `ena`, `cur_addr`, `proj_ui` and `uo_out` = 0.
- `cur_valid`, `sel_busy` and `sel_err` = 0.
- `proj_rst_n` = 0.

A reset mid-sequence aborts the sequence immediately.

States:
- IDLE: no project enabled, `proj_rst_n` = 0.
- DRAIN: one cycle. All `ena` = 0, `proj_rst_n` = 0, `sel_busy` = 1.
- HOLD: `ena[addr]` = 1, `proj_rst_n` = 0, `sel_busy` = 1. The hold counter counts 0..RST_HOLD-1.
- RUN: `ena[addr]` = 1, `proj_rst_n` = 1, `cur_valid` = 1, `cur_addr` = addr.

Transitions:
- IDLE or RUN, with `sel_req` and `sel_addr` < N_PROJ: latch the address and go to DRAIN. This also applies when the address equals the current one (the project is restarted).
- IDLE or RUN, with `sel_req` and `sel_addr` = F: go to IDLE. No `sel_err`.
- IDLE or RUN, with `sel_req` and N_PROJ ≤ `sel_addr` < F:
  - Go to IDLE, deselecting any running project.
  - Pulse `sel_err` in the next cycle.
- DRAIN: go to HOLD and clear the counter.
- HOLD: when the counter reaches RST_HOLD-1, go to RUN. Otherwise increment the counter.
- `sel_req` in DRAIN or HOLD: ignored. No `sel_err`, and the in-flight sequence continues.

Routing:
- `proj_ui` = `ui_in` in HOLD and RUN, otherwise 0. Projects see stable inputs during reset.
- `uo_out` = the `proj_uo` slice of `cur_addr` in RUN, otherwise 0.
- `ena` is never more than one-hot. A change of selection always passes through at least one all-zero cycle (DRAIN).

## Timing
Take `sel_req` sampled at edge T0:
- T0+1: DRAIN, `sel_busy` = 1.
- T0+2 .. T0+1+RST_HOLD: HOLD, with `ena` high.
- T0+2+RST_HOLD: RUN, with `proj_rst_n` = 1, `sel_busy` = 0 and `cur_valid` = 1.
- Total select latency is RST_HOLD+2 cycles.

Other timing:
- Deselect and rejected requests take effect at T0+1.
- `sel_err` is high only during the cycle after T0.
- `uo_out` and `proj_ui` are combinational from the inputs and the registered state. There are no added cycles.
- Outputs `sel_busy`, `cur_valid`, `cur_addr`, `ena` and `proj_rst_n` are registered.

## Configuration
- Macro `TT_SEQ_UO_REG_EN`.
- When defined: `uo_out` is registered. It follows the mux result with one cycle of latency, and is 0 in the first RUN cycle. Reset clears the register to 0.
- When undefined: `uo_out` is combinational as described above.

## Test plan
- Select: reset, then `sel_req` with addr = 2, N_PROJ = 4 and RST_HOLD = 8.
  - Required: `ena` = 0000 at T0+1; `ena` = 0100 with `proj_rst_n` = 0 from T0+2 to T0+9.
  - Required: RUN at T0+10, `cur_addr` = 2, and `uo_out` equal to `proj_uo[23:16]`.
- Switch: in RUN on project 1, request addr 3.
  - Required: exactly one cycle with `ena` = 0000.
  - Required: `ena` never has two bits set.
  - Required: `uo_out` = 0 until RUN, then equals `proj_uo[31:24]`.
- Invalid and deselect: in RUN, request addr 5.
  - Required: IDLE at T0+1 and `sel_err` = 1 for exactly one cycle.
  - Then request addr F: IDLE with `sel_err` = 0.
- Busy: `sel_req` with addr = 0 during HOLD.
  - Required: ignored; the sequence completes on the original address with no `sel_err`.
- Reset mid-HOLD: assert `rst` in the 4th HOLD cycle.
  - Required: all outputs are at their reset values at the next edge.
  - Required: the next select runs the full sequence.
- Same-address restart: in RUN on project 0, request addr 0.
  - Required: DRAIN, then `proj_rst_n` low for RST_HOLD cycles, then RUN.
  - With `TT_SEQ_UO_REG_EN` defined: `uo_out` lags the mux by 1 cycle.
